muldiv_unit: RTL and testbench

Iterative HI/LO multiply/divide unit for the MIPS core. It executes multu and divu sequentially over 32 cycles and handles mthi/mtlo writes. It owns the HI and LO registers and raises a stall request when mfhi or mflo arrives while an operation is in flight. It sits beside the ALU and is started by decoder-derived control signals.

---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit.
// Runs multu (shift-add) and divu (restoring) over WIDTH cycles and handles
// mthi/mtlo writes. It owns HI/LO and requests a stall when the core reads
// HI/LO while an operation is in flight.
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous, active-high reset
//   start   request operation op this cycle
//   op      00 multu, 01 divu, 10 mthi, 11 mtlo
//   a       rs operand (multiplicand / dividend / mthi-mtlo source)
//   b       rt operand (multiplier / divisor)
//   rd_req  core is executing mfhi/mflo this cycle
//   hi, lo  HI and LO registers
//   busy    multu/divu in progress
//   done    one-cycle pulse after HI/LO receive a multu/divu result
//   stall   rd_req & busy
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo and divide-by-zero complete here
// MUL   | one multiplier bit per cycle, WIDTH cycles
// DIV   | one quotient bit per cycle, WIDTH cycles
// FIN   | result written last edge; done pulse; accepts a new start
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   op_a;     // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0]   op_b;     // multiplier shifting right, or divisor
  logic [2*WIDTH-1:0] acc;      // product accumulator; remainder in acc[WIDTH:0]
  logic [CW-1:0]      cnt;
  logic               last;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH:0]     div_rem;
  logic               div_ge;
  logic [WIDTH-1:0]   div_q;

  assign last = (cnt == CW'(WIDTH - 1));

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  // The carry out of the add becomes the new top bit.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (op_b[0] ? op_a : '0)};
  assign acc_mul = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide with a WIDTH+1-bit partial remainder so divisors with
  // the top bit set cannot overflow the trial subtract.
  assign div_shift = {acc[WIDTH-1:0], op_a[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, op_b});
  assign div_diff  = div_shift - {1'b0, op_b};
  assign div_rem   = div_ge ? div_diff : div_shift;
  assign div_q     = {op_a[WIDTH-2:0], div_ge};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        state_nxt = IDLE;
        if (start) begin
          case (op)
            2'b00:   state_nxt = MUL;
            2'b01:   state_nxt = (b != '0) ? DIV : FIN;
            default: state_nxt = IDLE;
          endcase
        end
      end
      MUL:     if (last) state_nxt = FIN;
      DIV:     if (last) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      MUL, DIV: busy = 1'b1;
      FIN:      done = 1'b1;
      default:  ;
    endcase
  end

  assign stall = rd_req & busy;

  // Datapath and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      op_a <= '0;
      op_b <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            case (op)
              2'b00: begin
                op_a <= a;
                op_b <= b;
                acc  <= '0;
                cnt  <= '0;
              end
              2'b01: begin
                if (b != '0) begin
                  op_a <= a;
                  op_b <= b;
                  acc  <= '0;
                  cnt  <= '0;
                end else begin
                  // Divide by zero completes immediately; FIN only pulses done.
                  hi <= a;
                  lo <= '1;
                end
              end
              2'b10: hi <= a;
              default: lo <= a;
            endcase
          end
        end
        MUL: begin
          acc  <= acc_mul;
          op_b <= op_b >> 1;
          if (last) begin
            {hi, lo} <= acc_mul;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          acc  <= {{(WIDTH-1){1'b0}}, div_rem};
          op_a <= div_q;
          if (last) begin
            lo  <= div_q;
            hi  <= div_rem[WIDTH-1:0];
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH=32).
// Expected {hi,lo} pairs come from a small arithmetic model and are queued
// when an operation is issued, then popped when done is observed.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rd_req;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         stall;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] sb_q[$];
  logic [2*W-1:0] exp_hl;
  int             busy_cycles;
  bit             got_done;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_req(rd_req), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {hi, lo} for multu / divu.
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [2*W-1:0] p;
    if (o == 2'b00) begin
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      return p;
    end
    if (y == '0) return {x, {W{1'b1}}};
    return {x % y, x / y};
  endfunction

  // Issues one multu/divu, queues its expected result and waits for done.
  // Returns with the bench #1 after the edge that raised done (FIN cycle).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0;
    busy_cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; rd_req = 1'b1;
    #12;
    checks++;
    if ({hi, lo} !== '0) begin
      errors++; $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo);
    end
    checks++;
    if ({busy, done, stall} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: busy/done/stall got %b want 000", {busy, done, stall});
    end
    @(negedge clk);
    reset = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_mul_max();
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_hl = sb_q.pop_front();
    checks++;
    if (!got_done) begin
      errors++; $display("FAIL mul_max_done: got no done want done");
    end
    checks++;
    if (busy_cycles !== 32) begin
      errors++; $display("FAIL mul_max_busy: got %0d busy cycles want 32", busy_cycles);
    end
    checks++;
    if ({hi, lo} !== exp_hl || exp_hl !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL mul_max_result: got %h_%h want %h", hi, lo, exp_hl);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse: done/busy got %b%b want 00", done, busy);
    end
  endtask

  task automatic test_div();
    logic [W-1:0] da[3] = '{32'd100, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] db[3] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int k = 0; k < 3; k++) begin
      run_op(2'b01, da[k], db[k]);
      exp_hl = sb_q.pop_front();
      checks++;
      if (!got_done || busy_cycles !== 32) begin
        errors++;
        $display("FAIL div%0d_timing: done %0b busy cycles %0d want 1 and 32", k, got_done, busy_cycles);
      end
      checks++;
      if ({hi, lo} !== exp_hl) begin
        errors++; $display("FAIL div%0d_result: got %h_%h want %h", k, hi, lo, exp_hl);
      end
    end
  endtask

  task automatic test_div_zero();
    run_op(2'b01, 32'd1234, 32'd0);
    exp_hl = sb_q.pop_front();
    checks++;
    if (!got_done || busy_cycles !== 0) begin
      errors++; $display("FAIL div0_timing: done %0b busy cycles %0d want 1 and 0", got_done, busy_cycles);
    end
    checks++;
    if ({hi, lo} !== {32'd1234, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL div0_result: got %h_%h want %h", hi, lo, exp_hl);
    end
  endtask

  task automatic test_stall_ignore();
    int stall_cnt;
    int bad_stall;
    stall_cnt = 0;
    bad_stall = 0;
    got_done = 1'b0;
    @(negedge clk);
    rd_req = 1'b1;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    sb_q.push_back(model(2'b00, 32'd3, 32'd5));
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (stall) stall_cnt++;
      if (stall !== 1'b1) bad_stall++;
      if (i == 10) begin
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    exp_hl = sb_q.pop_front();
    checks++;
    if (!got_done || stall_cnt !== 32 || bad_stall !== 0) begin
      errors++;
      $display("FAIL stall_cycles: done %0b stall cycles %0d low-while-busy %0d want 1, 32, 0",
               got_done, stall_cnt, bad_stall);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL stall_done: got %b want 0", stall);
    end
    checks++;
    if ({hi, lo} !== exp_hl) begin
      errors++; $display("FAIL ignored_start: got %h_%h want %h", hi, lo, exp_hl);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ignored_start_idle: busy/done got %b%b want 00", busy, done);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'hDEAD_BEEF; b = 32'd0;
    @(posedge clk); #1;
    op = 2'b11; a = 32'hCAFE_F00D;
    checks++;
    if (hi !== 32'hDEAD_BEEF || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mthi: hi %h busy %b done %b want deadbeef 0 0", hi, busy, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({hi, lo} !== {32'hDEAD_BEEF, 32'hCAFE_F00D} || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: got %h_%h busy %b done %b want deadbeef_cafef00d 0 0", hi, lo, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    // Second operation is issued during the FIN cycle of the first.
    run_op(2'b00, 32'd6, 32'd7);
    exp_hl = sb_q.pop_front();
    checks++;
    if ({hi, lo} !== exp_hl) begin
      errors++; $display("FAIL b2b_mul: got %h_%h want %h", hi, lo, exp_hl);
    end
    run_op(2'b01, 32'hFFFF_FFFF, 32'd10);
    exp_hl = sb_q.pop_front();
    checks++;
    if (!got_done || busy_cycles !== 32 || {hi, lo} !== exp_hl) begin
      errors++;
      $display("FAIL b2b_div: got %h_%h busy %0d want %h busy 32", hi, lo, busy_cycles, exp_hl);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd1000; b = 32'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({hi, lo} !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got %h_%h busy %b done %b want 0_0 0 0", hi, lo, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || {hi, lo} !== '0) begin
      errors++; $display("FAIL reset_abort: done %b hi_lo %h_%h want 0 0_0", done, hi, lo);
    end
    run_op(2'b00, 32'd2, 32'd2);
    exp_hl = sb_q.pop_front();
    checks++;
    if (!got_done || busy_cycles !== 32 || {hi, lo} !== exp_hl) begin
      errors++;
      $display("FAIL reset_rerun: got %h_%h busy %0d want %h busy 32", hi, lo, busy_cycles, exp_hl);
    end
  endtask

  task automatic test_random();
    logic [1:0]   o;
    logic [W-1:0] x, y;
    for (int k = 0; k < 6; k++) begin
      o = (k % 2 == 0) ? 2'b00 : 2'b01;
      x = $urandom;
      y = $urandom;
      run_op(o, x, y);
      exp_hl = sb_q.pop_front();
      checks++;
      if (!got_done || {hi, lo} !== exp_hl) begin
        errors++;
        $display("FAIL rand%0d op%0d %h,%h: got %h_%h want %h", k, o, x, y, hi, lo, exp_hl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_max();
    test_div();
    test_div_zero();
    test_stall_ignore();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
